// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame width and the baud divisor helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } uart_state_t;

    localparam int DATA_BITS = 8;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs; both stages reset to all ones.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a one-entry valid/ready output register.
// Define UART_RX_PARITY_EN to receive an even parity bit and add the parity_err output.
//
//   state  | meaning
//   IDLE   | line high, waiting for a falling edge
//   START  | qualifying the start bit at its midpoint
//   DATA   | sampling 8 data bits, LSB first
//   PARITY | sampling the parity bit (parity build only)
//   STOP   | sampling the stop bit, then deliver or flag
//   BREAK  | stop bit was low; wait for the line to return high
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ       = 27000000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 busy,
    output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    if (CLKS_PER_BIT < 4) begin : g_bad_cpb
        $error("uart_rx: CLKS_PER_BIT must be >= 4");
    end

    uart_state_t          state, state_nxt;
    logic [CW-1:0]        clk_cnt;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 rx_s;
    logic                 at_max;
    logic                 cnt_clr, bit_smp, deliver, ferr_set;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit, par_smp, perr_set;
`endif

    sync_2ff #(.W(1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    assign at_max = (clk_cnt == CNT_MAX);
    assign busy   = (state != IDLE);

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        bit_smp   = 1'b0;
        deliver   = 1'b0;
        ferr_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_smp   = 1'b0;
        perr_set  = 1'b0;
`endif
        case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                if (!rx_s) state_nxt = START;
            end
            START: begin
                if (clk_cnt == CNT_HALF) begin
                    cnt_clr   = 1'b1;
                    state_nxt = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (at_max) begin
                    bit_smp = 1'b1;
`ifdef UART_RX_PARITY_EN
                    if (bit_idx == 3'd7) state_nxt = PARITY;
`else
                    if (bit_idx == 3'd7) state_nxt = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (at_max) begin
                    par_smp   = 1'b1;
                    state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                if (at_max) begin
                    if (!rx_s) begin
                        ferr_set  = 1'b1;
                        state_nxt = BREAK;
                    end else begin
`ifdef UART_RX_PARITY_EN
                        if (^{shift, par_bit}) perr_set = 1'b1;
                        else                   deliver  = 1'b1;
`else
                        deliver = 1'b1;
`endif
                        state_nxt = IDLE;
                    end
                end
            end
            BREAK: begin
                if (rx_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            clk_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state <= state_nxt;
            if (cnt_clr || at_max) clk_cnt <= '0;
            else                   clk_cnt <= clk_cnt + 1'b1;
            if (cnt_clr)      bit_idx <= '0;
            else if (bit_smp) bit_idx <= bit_idx + 3'd1;
            if (bit_smp) shift[bit_idx] <= rx_s;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (par_smp) par_bit <= rx_s;
            parity_err <= perr_set;
        end
    end
`endif

    // A completing byte may replace the held one only if it is being accepted this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr_set;
            overrun   <= deliver && rx_valid && !rx_ready;
            if (deliver && (!rx_valid || rx_ready)) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver for the 8N1 UART link; the downstream consumer of the board's transmit stage, used for loopback and host-to-FPGA traffic.
- Synchronises the asynchronous rx line and samples each bit at mid-bit.
- Delivers bytes on a one-entry valid/ready output register.
- Flags framing and overrun errors with single-cycle pulses.

Parameters:
- CLK_HZ, 27000000, system clock frequency in Hz.
- BAUD, 115200, line bit rate.
- CLKS_PER_BIT, CLK_HZ/BAUD, clocks per bit period. Must be >= 4; checked at elaboration.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rx  in  1  serial line; idles high; asynchronous to clk.
- rx_data  out  8  received byte; valid while rx_valid=1.
- rx_valid  out  1  byte available; held until accepted.
- rx_ready  in  1  consumer accepts when rx_valid & rx_ready at a clk edge.
- busy  out  1  high in any state except IDLE.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: byte completed while output register full and not being accepted.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: rx_data=0, rx_valid=0, busy=0, frame_err=0, overrun=0, state=IDLE, counters=0, synchroniser flops=1.
- Synchroniser: rx passes through 2 flops (rx_s). All decisions use rx_s, so the line-to-detect latency is 2 clocks.
- Bit counter: clk_cnt has width $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps to 0. bit_idx is 3 bits.
- IDLE:
  - On rx_s=0, go to START and clear clk_cnt.
- START:
  - When clk_cnt = CLKS_PER_BIT/2 - 1 (integer division), resample rx_s.
  - If rx_s=1, it is a false start (glitch): return to IDLE. No error is flagged.
  - Otherwise go to DATA and clear clk_cnt and bit_idx.
- DATA:
  - When clk_cnt = CLKS_PER_BIT-1, sample rx_s into shift[bit_idx]. LSB is received first.
  - After bit_idx=7 is sampled, go to STOP. Otherwise increment bit_idx.
- STOP:
  - When clk_cnt = CLKS_PER_BIT-1, sample rx_s.
  - If rx_s=1: deliver the byte (see below), then go to IDLE.
  - If rx_s=0: pulse frame_err, discard the byte, go to BREAK.
- BREAK:
  - Wait for rx_s=1, then go to IDLE. This prevents a held-low line from retriggering receive.
- Delivery rules:
  - If rx_valid=0, or rx_ready=1 in the same cycle: load rx_data and set rx_valid=1. This is a simultaneous accept-and-load with no bubble.
  - If rx_valid=1 and rx_ready=0: pulse overrun. The new byte is dropped and the old rx_data is retained.
- Acceptance: rx_valid & rx_ready with no new byte completing clears rx_valid next cycle.
- rx_data is stable while rx_valid=1.
- Latency: rx_valid rises 1 clock after the mid-stop sample, roughly 9.5 bit times after the start edge plus the 2-clock synchroniser.
- Reset mid-frame aborts immediately. After release, the receiver waits in IDLE for the next falling edge. A partial frame in progress may be misread as a start; that is accepted behaviour.
- frame_err and overrun are never both asserted in the same cycle.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP. It samples one bit at mid-bit.
  - Even parity is expected: XOR of the 8 data bits and the parity bit must be 0.
  - Adds output port parity_err (1 bit), a one-cycle pulse issued at the stop-sample cycle when parity mismatches. The byte is discarded, not delivered.
  - If both stop and parity fail, only frame_err pulses.
- Undefined: the frame is 8N1, there is no PARITY state, and the parity_err port is absent.

Decomposition:
- Package uart_pkg holds:
  - state encoding constants: IDLE, START, DATA, PARITY, STOP, BREAK (3 bits);
  - DATA_BITS=8;
  - the function clks_per_bit(clk_hz, baud), shared with the transmit side.
- One natural sub-module, sync_2ff: a parameterised-width 2-flop synchroniser with reset value 1, reusable for other async inputs.

Test Plan:
All scenarios use CLK_HZ=1000000 and BAUD=100000, so CLKS_PER_BIT=10.
1. Send 0xA5 as 8N1 with rx_ready=1 -> rx_valid pulses for 1 clock with rx_data=0xA5; frame_err=0, overrun=0; busy low after the stop bit.
2. Send 0x3C then 0xC3 back-to-back with rx_ready=0, then raise rx_ready -> first byte 0x3C held; overrun pulses once at the second stop; rx_data stays 0x3C until accepted.
3. Drive rx low for 3 clocks, then high -> no rx_valid, no frame_err; busy returns to 0 within 10 clocks.
4. Send 0x55 with the stop bit held low for 30 clocks -> frame_err pulses once, no rx_valid; busy stays high until rx returns high; the next frame 0x12 is received correctly.
5. Assert rst_n=0 during data bit 4 of 0xFF, release, then send 0x81 -> all outputs 0 during reset; 0x81 is delivered correctly.
6. With UART_RX_PARITY_EN: send 0x07 with parity bit 1 -> delivered. Send 0x07 with parity bit 0 -> parity_err pulses, no rx_valid.
